peripheral_division_param: RTL and testbench

Parametrised successor of the 32-bit memory-mapped divider peripheral, on the same 16-bit cs/rd/wr/addr bus.
- Runs a sequential restoring division, one quotient bit per clock, in signed or unsigned mode.
- Exposes quotient, remainder, busy, done and divide-by-zero status.
- The register map is a superset of the 32-bit divider map, so existing firmware reaches its registers unchanged.

---
 rtl/div_pkg.sv | 35 +++
 rtl/peripheral_division_param_if.sv | 14 +
 rtl/div_core_seq.sv | 162 ++++++++++++++++
 rtl/peripheral_division_param.sv | 172 +++++++++++++++++
 tb/tb_peripheral_division_param.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the parametrised divider peripheral: register map, CTRL/status bit
// positions and core FSM encoding. DIV_IRQ_EN relocates dbz in the status word.
package div_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_DVD_HI = 8'h02;
  localparam logic [7:0] ADDR_DVD_LO = 8'h04;
  localparam logic [7:0] ADDR_DSR_HI = 8'h06;
  localparam logic [7:0] ADDR_DSR_LO = 8'h08;
  localparam logic [7:0] ADDR_DONE   = 8'h0A;
  localparam logic [7:0] ADDR_QUO_HI = 8'h0C;
  localparam logic [7:0] ADDR_QUO_LO = 8'h0E;
  localparam logic [7:0] ADDR_REM_HI = 8'h10;
  localparam logic [7:0] ADDR_REM_LO = 8'h12;

  localparam int CTRL_GO_BIT     = 0;
  localparam int CTRL_SIGNED_BIT = 1;
  localparam int CTRL_IRQEN_BIT  = 2;

  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
`ifdef DIV_IRQ_EN
  localparam int STAT_IRQEN_BIT  = 2;
  localparam int STAT_DBZ_BIT    = 3;
`else
  localparam int STAT_DBZ_BIT    = 2;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/peripheral_division_param_if.sv
// Peripheral bus of the divider: 16-bit data, chip select, read/write strobes, word address.
interface peripheral_division_param_if #(
  parameter int ADDR_W = 5
);
  logic [15:0]       d_in;
  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [15:0]       d_out;

  modport master (output d_in, cs, addr, rd, wr, input d_out);
  modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/div_core_seq.sv
// Sequential restoring divider core: one quotient bit per clock on operand magnitudes,
// with sign fix-up and divide-by-zero handling in the final state.
module div_core_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             dvd_neg_s;
  logic             dsr_neg_s;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    dvd_d       = dvd_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    busy_d      = busy_q;
    done_d      = done_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    dvd_neg_s = signed_mode & dividend[WIDTH-1];
    dsr_neg_s = signed_mode & divisor[WIDTH-1];
    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dsr_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d     = dividend;
          rem_d     = '0;
          quo_d     = apply_sign(dividend, dvd_neg_s);
          dsr_d     = apply_sign(divisor, dsr_neg_s);
          neg_quo_d = dvd_neg_s ^ dsr_neg_s;
          neg_rem_d = dvd_neg_s;
          count_d   = CNT_W'(WIDTH - 1);
          busy_d    = 1'b1;
          done_d    = 1'b0;
          dbz_d     = 1'b0;
          if (divisor == '0) begin
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!diff_s[WIDTH]) begin
          rem_d = diff_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (count_q == '0) begin
          state_d = FIX;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (dsr_q == '0) begin
          dbz_d       = 1'b1;
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else begin
          dbz_d       = 1'b0;
          quotient_d  = apply_sign(quo_q, neg_quo_q);
          remainder_d = apply_sign(rem_q, neg_rem_q);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      dvd_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      dvd_q       <= dvd_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: rtl/peripheral_division_param.sv
// Memory-mapped divider peripheral: bus decode, operand/control registers and registered read mux
// around div_core_seq. Defining DIV_IRQ_EN adds the irq output and CTRL/status irq_enable bit.
module peripheral_division_param
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic clk,
  input  logic rst,
  peripheral_division_param_if.slave bus
`ifdef DIV_IRQ_EN
  ,
  output logic irq
`endif
);

  localparam logic HAS_HI = (WIDTH == 32);

  logic [15:0] dvd_hi_q, dvd_hi_d;
  logic [15:0] dvd_lo_q, dvd_lo_d;
  logic [15:0] dsr_hi_q, dsr_hi_d;
  logic [15:0] dsr_lo_q, dsr_lo_d;
  logic        signed_q, signed_d;
  logic        go_q, go_d;
  logic [15:0] d_out_q, d_out_d;
`ifdef DIV_IRQ_EN
  logic        irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
  logic        done_prev_q, done_prev_d;
`endif

  logic             wr_en_s;
  logic             rd_en_s;
  logic             busy_s;
  logic             done_s;
  logic             dbz_s;
  logic [WIDTH-1:0] quotient_s;
  logic [WIDTH-1:0] remainder_s;
  logic [31:0]      quo_ext_s;
  logic [31:0]      rem_ext_s;
  logic [15:0]      status_s;
  logic [15:0]      rd_data_s;

  assign wr_en_s   = bus.cs & bus.wr;
  assign rd_en_s   = bus.cs & bus.rd;
  assign quo_ext_s = 32'(quotient_s);
  assign rem_ext_s = 32'(remainder_s);

  // go is a one-cycle pulse; the core latches operands on the edge after the CTRL write
  div_core_seq #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .start       (go_q),
    .signed_mode (signed_q),
    .dividend    (WIDTH'({dvd_hi_q, dvd_lo_q})),
    .divisor     (WIDTH'({dsr_hi_q, dsr_lo_q})),
    .busy        (busy_s),
    .done        (done_s),
    .dbz         (dbz_s),
    .quotient    (quotient_s),
    .remainder   (remainder_s)
  );

  always_comb begin
    status_s                = 16'h0000;
    status_s[STAT_BUSY_BIT] = busy_s;
    status_s[STAT_DONE_BIT] = done_s;
    status_s[STAT_DBZ_BIT]  = dbz_s;
`ifdef DIV_IRQ_EN
    status_s[STAT_IRQEN_BIT] = irq_en_q;
`endif
    case (bus.addr)
      ADDR_W'(ADDR_CTRL):   rd_data_s = status_s;
      ADDR_W'(ADDR_DVD_HI): rd_data_s = HAS_HI ? dvd_hi_q : 16'h0000;
      ADDR_W'(ADDR_DVD_LO): rd_data_s = dvd_lo_q;
      ADDR_W'(ADDR_DSR_HI): rd_data_s = HAS_HI ? dsr_hi_q : 16'h0000;
      ADDR_W'(ADDR_DSR_LO): rd_data_s = dsr_lo_q;
      ADDR_W'(ADDR_DONE):   rd_data_s = {15'h0000, done_s};
      ADDR_W'(ADDR_QUO_HI): rd_data_s = HAS_HI ? quo_ext_s[31:16] : 16'h0000;
      ADDR_W'(ADDR_QUO_LO): rd_data_s = quo_ext_s[15:0];
      ADDR_W'(ADDR_REM_HI): rd_data_s = HAS_HI ? rem_ext_s[31:16] : 16'h0000;
      ADDR_W'(ADDR_REM_LO): rd_data_s = rem_ext_s[15:0];
      default:              rd_data_s = 16'h0000;
    endcase
  end

  always_comb begin
    dvd_hi_d = dvd_hi_q;
    dvd_lo_d = dvd_lo_q;
    dsr_hi_d = dsr_hi_q;
    dsr_lo_d = dsr_lo_q;
    signed_d = signed_q;
    go_d     = 1'b0;
    d_out_d  = rd_en_s ? rd_data_s : 16'h0000;
`ifdef DIV_IRQ_EN
    irq_en_d    = irq_en_q;
    done_prev_d = done_s;
`endif
    if (wr_en_s) begin
      case (bus.addr)
        ADDR_W'(ADDR_CTRL): begin
          go_d = bus.d_in[CTRL_GO_BIT];
          if (bus.d_in[CTRL_GO_BIT]) begin
            signed_d = bus.d_in[CTRL_SIGNED_BIT];
          end else begin
            signed_d = signed_q;
          end
`ifdef DIV_IRQ_EN
          irq_en_d = bus.d_in[CTRL_IRQEN_BIT];
`endif
        end
        ADDR_W'(ADDR_DVD_HI): dvd_hi_d = HAS_HI ? bus.d_in : dvd_hi_q;
        ADDR_W'(ADDR_DVD_LO): dvd_lo_d = bus.d_in;
        ADDR_W'(ADDR_DSR_HI): dsr_hi_d = HAS_HI ? bus.d_in : dsr_hi_q;
        ADDR_W'(ADDR_DSR_LO): dsr_lo_d = bus.d_in;
        default:              go_d     = 1'b0;
      endcase
    end else begin
      go_d = 1'b0;
    end
  end

`ifdef DIV_IRQ_EN
  // a completion edge takes priority over a same-cycle clear
  always_comb begin
    if (done_s & ~done_prev_q & irq_en_q) begin
      irq_d = 1'b1;
    end else if ((rd_en_s & (bus.addr == ADDR_W'(ADDR_CTRL))) | (go_q & ~busy_s)) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_hi_q <= 16'h0000;
      dvd_lo_q <= 16'h0000;
      dsr_hi_q <= 16'h0000;
      dsr_lo_q <= 16'h0000;
      signed_q <= 1'b0;
      go_q     <= 1'b0;
      d_out_q  <= 16'h0000;
`ifdef DIV_IRQ_EN
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      done_prev_q <= 1'b0;
`endif
    end else begin
      dvd_hi_q <= dvd_hi_d;
      dvd_lo_q <= dvd_lo_d;
      dsr_hi_q <= dsr_hi_d;
      dsr_lo_q <= dsr_lo_d;
      signed_q <= signed_d;
      go_q     <= go_d;
      d_out_q  <= d_out_d;
`ifdef DIV_IRQ_EN
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      done_prev_q <= done_prev_d;
`endif
    end
  end

  assign bus.d_out = d_out_q;
`ifdef DIV_IRQ_EN
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_peripheral_division_param.sv
// Directed bench for peripheral_division_param (WIDTH=32): bus-level writes/reads with
// hand-computed quotients, remainders, status words and done latencies.
module tb_peripheral_division_param;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;
`ifdef DIV_IRQ_EN
  logic irq;
`endif

  always #5 clk = ~clk;

  peripheral_division_param_if #(.ADDR_W(5)) bus ();

  peripheral_division_param #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DIV_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat;
  logic [15:0] rdata;
  logic [31:0] rword;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // all bus tasks start and end at a falling edge
  task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.d_in = d;
    @(posedge clk); @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [15:0] d);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
    @(posedge clk); @(negedge clk);
    d = bus.d_out;
    bus.cs = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic read32(input logic [4:0] hi, input logic [4:0] lo, output logic [31:0] w);
    logic [15:0] h, l;
    bus_read(hi, h);
    bus_read(lo, l);
    w = {h, l};
  endtask

  task automatic set_ops(input logic [31:0] dvd, input logic [31:0] dsr);
    bus_write(ADDR_DVD_HI[4:0], dvd[31:16]);
    bus_write(ADDR_DVD_LO[4:0], dvd[15:0]);
    bus_write(ADDR_DSR_HI[4:0], dsr[31:16]);
    bus_write(ADDR_DSR_LO[4:0], dsr[15:0]);
  endtask

  // Continuous reads of 0x0A; returns k where the read at edge (start+k) first shows done.
  // Edge start+1 still shows the previous done, so hits start from k=2. Returns -1 on timeout.
  task automatic wait_done(output int cycles);
    cycles = -1;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = ADDR_DONE[4:0];
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); @(negedge clk);
      if (i >= 2 && bus.d_out == 16'h0001) begin
        cycles = i;
        break;
      end
    end
    bus.cs = 1'b0; bus.rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 5'h00; bus.d_in = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_dout", 32'(bus.d_out), 32'h0);
    bus_read(ADDR_CTRL[4:0], rdata);   check("rst_status", 32'(rdata), 32'h0);
    read32(ADDR_QUO_HI[4:0], ADDR_QUO_LO[4:0], rword); check("rst_quo", rword, 32'h0);
    read32(ADDR_REM_HI[4:0], ADDR_REM_LO[4:0], rword); check("rst_rem", rword, 32'h0);

    // unsigned 1000/5; done at go+34 is first seen by the read at go+35
    set_ops(32'd1000, 32'd5);
    bus_write(ADDR_CTRL[4:0], 16'h0001);
    wait_done(lat);                    check("t1_latency", 32'(lat), 32'd35);
    bus_read(ADDR_QUO_HI[4:0], rdata); check("t1_quo_hi", 32'(rdata), 32'h0);
    bus_read(ADDR_QUO_LO[4:0], rdata); check("t1_quo_lo", 32'(rdata), 32'h00C8);
    read32(ADDR_REM_HI[4:0], ADDR_REM_LO[4:0], rword); check("t1_rem", rword, 32'h0);
    bus_read(ADDR_CTRL[4:0], rdata);   check("t1_status", 32'(rdata), 32'h0002);
    @(posedge clk); @(negedge clk);
    check("idle_dout_zero", 32'(bus.d_out), 32'h0);
    bus_read(5'h14, rdata);            check("unmapped_read", 32'(rdata), 32'h0);

    // signed -7/2
    set_ops(32'hFFFF_FFF9, 32'd2);
    bus_write(ADDR_CTRL[4:0], 16'h0003);
    wait_done(lat);                    check("t2_latency", 32'(lat), 32'd35);
    read32(ADDR_QUO_HI[4:0], ADDR_QUO_LO[4:0], rword); check("t2_quo", rword, 32'hFFFF_FFFD);
    read32(ADDR_REM_HI[4:0], ADDR_REM_LO[4:0], rword); check("t2_rem", rword, 32'hFFFF_FFFF);
    bus_read(ADDR_CTRL[4:0], rdata);   check("t2_status", 32'(rdata), 32'h0002);

    // unsigned 1234/0
    set_ops(32'd1234, 32'd0);
    bus_write(ADDR_CTRL[4:0], 16'h0001);
    wait_done(lat);                    check("t3_latency", 32'(lat), 32'd3);
    read32(ADDR_QUO_HI[4:0], ADDR_QUO_LO[4:0], rword); check("t3_quo", rword, 32'hFFFF_FFFF);
    read32(ADDR_REM_HI[4:0], ADDR_REM_LO[4:0], rword); check("t3_rem", rword, 32'h0000_04D2);
    bus_read(ADDR_CTRL[4:0], rdata);   check("t3_status", 32'(rdata), 32'h0006);

    // signed MIN / -1
    set_ops(32'h8000_0000, 32'hFFFF_FFFF);
    bus_write(ADDR_CTRL[4:0], 16'h0003);
    wait_done(lat);                    check("t4_latency", 32'(lat), 32'd35);
    read32(ADDR_QUO_HI[4:0], ADDR_QUO_LO[4:0], rword); check("t4_quo", rword, 32'h8000_0000);
    read32(ADDR_REM_HI[4:0], ADDR_REM_LO[4:0], rword); check("t4_rem", rword, 32'h0);
    bus_read(ADDR_CTRL[4:0], rdata);   check("t4_status", 32'(rdata), 32'h0002);

    // 100/7 with an operand write at go+5 and a second go at go+6; polling starts at go+7
    set_ops(32'd100, 32'd7);
    bus_write(ADDR_CTRL[4:0], 16'h0001);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus_write(ADDR_DVD_LO[4:0], 16'd50);
    bus_write(ADDR_CTRL[4:0], 16'h0001);
    wait_done(lat);                    check("t5_latency", 32'(lat), 32'd29);
    read32(ADDR_QUO_HI[4:0], ADDR_QUO_LO[4:0], rword); check("t5_quo", rword, 32'd14);
    read32(ADDR_REM_HI[4:0], ADDR_REM_LO[4:0], rword); check("t5_rem", rword, 32'd2);
    bus_read(ADDR_CTRL[4:0], rdata);   check("t5_status", 32'(rdata), 32'h0002);

    // reset at go+10 aborts; a fresh division then completes
    set_ops(32'd100, 32'd7);
    bus_write(ADDR_CTRL[4:0], 16'h0001);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bus_read(ADDR_CTRL[4:0], rdata);   check("t6_status_after_rst", 32'(rdata), 32'h0);
    bus_read(ADDR_QUO_LO[4:0], rdata); check("t6_quo_after_rst", 32'(rdata), 32'h0);
    set_ops(32'd1000, 32'd5);
    bus_write(ADDR_CTRL[4:0], 16'h0001);
    wait_done(lat);                    check("t6_latency", 32'(lat), 32'd35);
    bus_read(ADDR_QUO_LO[4:0], rdata); check("t6_quo_lo", 32'(rdata), 32'h00C8);

    // simultaneous read and write: write lands, d_out shows the old value
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = ADDR_DVD_LO[4:0]; bus.d_in = 16'h1111;
    @(posedge clk); @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    check("rw_same_cycle_dout", 32'(bus.d_out), 32'h03E8);
    bus_read(ADDR_DVD_LO[4:0], rdata); check("rw_same_cycle_write", 32'(rdata), 32'h1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
